pw_symbol_decoder: RTL and testbench

Receiver for the pulse-width symbol stream produced by the lab clock-switcher encoder. It samples a single asynchronous line and measures the high phase of each symbol to decide its bit value. A short high phase decodes as 0 and a long one as 1. Bits are assembled into a frame of up to 4 bits, and the frame is reported with a one-cycle `valid` pulse once the line has been idle long enough. It sits at the far end of the link, on the board that consumes the encoded pattern.

---
 rtl/pw_symbol_decoder.sv | 187 ++++++++++++++++++
 tb/tb_pw_symbol_decoder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pw_symbol_decoder.sv
// Pulse-width symbol decoder: short high phase is 0, long is 1, frame ends on idle low.
// Optional PWDEC_GLITCH_FILTER_EN adds a 3-sample level filter after the synchronizer.
module pw_symbol_decoder #(
  parameter int unsigned T_THRESH   = 500,
  parameter int unsigned T_MIN_HIGH = 125,
  parameter int unsigned T_MAX_HIGH = 1125,
  parameter int unsigned T_IDLE_LOW = 1500,
  parameter int unsigned CW         = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic [3:0] bits_out,
  output logic [2:0] count_out,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STUCK = 2'd3
  } state_t;

  localparam logic [CW-1:0] THR    = CW'(T_THRESH);
  localparam logic [CW-1:0] MINH   = CW'(T_MIN_HIGH);
  localparam logic [CW-1:0] MAXH_M = CW'(T_MAX_HIGH - 1);
  localparam logic [CW-1:0] IDLE_M = CW'(T_IDLE_LOW - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic s1_q, s2_q;
  logic ds, ds_prev_q, rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

`ifdef PWDEC_GLITCH_FILTER_EN
  logic h1_q, h2_q, dsf_q;

  // ds follows only once the last three synchronized samples agree
  assign ds = (s2_q == h1_q && h1_q == h2_q) ? s2_q : dsf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h1_q  <= 1'b0;
      h2_q  <= 1'b0;
      dsf_q <= 1'b0;
    end else begin
      h1_q  <= s2_q;
      h2_q  <= h1_q;
      dsf_q <= ds;
    end
  end
`else
  assign ds = s2_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ds_prev_q <= 1'b0;
    else        ds_prev_q <= ds;
  end

  assign rise = ds & ~ds_prev_q;

  state_t        state_q, state_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] lcnt_q, lcnt_d;
  logic [3:0]    store_q, store_d;
  logic [2:0]    nbits_q, nbits_d;
  logic          ferr_q, ferr_d;
  logic          valid_q, valid_d;
  logic [3:0]    bits_q, bits_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          err_q, err_d;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == '1) ? c : c + ONE;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
      store_q <= '0;
      nbits_q <= '0;
      ferr_q  <= 1'b0;
      valid_q <= 1'b0;
      bits_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
      store_q <= store_d;
      nbits_q <= nbits_d;
      ferr_q  <= ferr_d;
      valid_q <= valid_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    lcnt_d  = lcnt_q;
    store_d = store_q;
    nbits_d = nbits_q;
    ferr_d  = ferr_q;
    valid_d = 1'b0;
    bits_d  = bits_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          store_d = '0;
          nbits_d = '0;
          ferr_d  = 1'b0;
          hcnt_d  = ONE;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (ds) begin
          hcnt_d = sat_inc(hcnt_q);
          if (hcnt_q >= MAXH_M) begin
            valid_d = 1'b1;
            bits_d  = store_q;
            cnt_d   = nbits_q;
            err_d   = 1'b1;
            state_d = STUCK;
          end
        end else begin
          if (hcnt_q < MINH) begin
            ferr_d = 1'b1;
          end else if (nbits_q < 3'd4) begin
            store_d[nbits_q[1:0]] = (hcnt_q >= THR);
            nbits_d = nbits_q + 3'd1;
          end else begin
            ferr_d = 1'b1;
          end
          lcnt_d  = ONE;
          state_d = LOW;
        end
      end
      LOW: begin
        if (ds) begin
          hcnt_d  = ONE;
          state_d = HIGH;
        end else begin
          lcnt_d = sat_inc(lcnt_q);
          if (lcnt_q >= IDLE_M) begin
            valid_d = 1'b1;
            bits_d  = store_q;
            cnt_d   = nbits_q;
            err_d   = ferr_q;
            state_d = IDLE;
          end
        end
      end
      STUCK: begin
        if (!ds) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bits_out  = bits_q;
  assign count_out = cnt_q;
  assign valid     = valid_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pw_symbol_decoder.sv
// Directed bench for pw_symbol_decoder: vector table of frames plus
// hand-written stuck-high, glitch and mid-frame reset sequences.
module tb_pw_symbol_decoder;

`ifdef PWDEC_GLITCH_FILTER_EN
  localparam int FL = 2;
`else
  localparam int FL = 0;
`endif
  localparam int LAT_IDLE = 1502 + FL;
  localparam int LAT_STUCK = 1127 + FL;

  logic       clk = 1'b0;
  logic       reset;
  logic       din;
  logic [3:0] bits_out;
  logic [2:0] count_out;
  logic       valid, err, busy;

  pw_symbol_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .bits_out  (bits_out),
    .count_out (count_out),
    .valid     (valid),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]       n;
    logic [4:0][10:0] hi;
    logic [3:0]       bits;
    logic [2:0]       cnt;
    logic             err;
  } vec_t;

  function automatic vec_t mk(int n, int h0, int h1, int h2, int h3,
                              int h4, logic [3:0] b, int c, logic e);
    vec_t v;
    v.n = 3'(n);
    v.hi[0] = 11'(h0);
    v.hi[1] = 11'(h1);
    v.hi[2] = 11'(h2);
    v.hi[3] = 11'(h3);
    v.hi[4] = 11'(h4);
    v.bits = b;
    v.cnt = 3'(c);
    v.err = e;
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic hold(logic v, int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output int n,
                            output bit got);
    n = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (valid) got = 1'b1;
    end
  endtask

  task automatic sym(int h);
    hold(1'b0, (h >= 500) ? 750 : 250);
    hold(1'b1, h);
  endtask

  task automatic frame_end(string nm, logic [3:0] b, int c,
                           logic e, int lat);
    int n;
    bit got;
    chk({nm, "_busy"}, busy, 1);
    din = 1'b0;
    wait_valid(4000, n, got);
    chk({nm, "_got"}, got, 1);
    chk({nm, "_lat"}, n, lat);
    chk({nm, "_bits"}, bits_out, b);
    chk({nm, "_cnt"}, count_out, c);
    chk({nm, "_err"}, err, e);
    @(negedge clk);
    chk({nm, "_pulse"}, valid, 0);
    chk({nm, "_hold"}, bits_out, b);
    chk({nm, "_idle"}, busy, 0);
  endtask

  vec_t vt[9];

  initial begin
    int bad, vc, vat, n;
    bit got;
    logic verr;
    logic [2:0] vcnt;

    vt[0] = mk(3, 751, 251, 751, 0, 0, 4'b0101, 3, 1'b0);
    vt[1] = mk(5, 751, 751, 751, 751, 251, 4'b1111, 4, 1'b1);
    vt[2] = mk(1, 251, 0, 0, 0, 0, 4'b0000, 1, 1'b0);
    vt[3] = mk(4, 751, 751, 251, 251, 0, 4'b0011, 4, 1'b0);
    vt[4] = mk(4, 125, 499, 500, 124, 0, 4'b0100, 3, 1'b1);
    vt[5] = mk(2, 500, 499, 0, 0, 0, 4'b0001, 2, 1'b0);
    vt[6] = mk(1, 1124, 0, 0, 0, 0, 4'b0001, 1, 1'b0);
    vt[7] = mk(1, 50, 0, 0, 0, 0, 4'b0000, 0, 1'b1);
    vt[8] = mk(3, 124, 1124, 124, 0, 0, 4'b0001, 1, 1'b1);

    reset = 1'b1;
    din = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_bits", bits_out, 0);
    chk("rst_cnt", count_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (valid || busy || err || bits_out != 0 || count_out != 0)
        bad++;
    end
    chk("idle_quiet", bad, 0);

    for (int k = 0; k < 9; k++) begin
      for (int s = 0; s < int'(vt[k].n); s++) sym(int'(vt[k].hi[s]));
      frame_end($sformatf("vec%0d", k), vt[k].bits,
                int'(vt[k].cnt), vt[k].err, LAT_IDLE);
    end

    vc = 0;
    vat = 0;
    verr = 1'b0;
    vcnt = 3'd7;
    din = 1'b1;
    for (int i = 1; i <= 3000; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid) begin
        vc++;
        if (vc == 1) begin
          vat = i;
          verr = err;
          vcnt = count_out;
        end
      end
    end
    chk("stuck_nvalid", vc, 1);
    chk("stuck_lat", vat, LAT_STUCK);
    chk("stuck_err", verr, 1);
    chk("stuck_cnt", vcnt, 0);
    chk("stuck_busy", busy, 1);
    din = 1'b0;
    vc = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (valid) vc++;
    end
    chk("stuck_novalid", vc, 0);
    chk("stuck_release", busy, 0);

    hold(1'b0, 250);
    hold(1'b1, 251);
    hold(1'b0, 300);
    hold(1'b1, 2);
    hold(1'b0, 448);
    hold(1'b1, 751);
    frame_end("glitch", 4'b0010, 2, (FL == 0) ? 1'b1 : 1'b0,
              LAT_IDLE);

    hold(1'b0, 750);
    hold(1'b1, 751);
    hold(1'b0, 250);
    hold(1'b1, 400);
    reset = 1'b0;
    #1;
    chk("mrst_bits", bits_out, 0);
    chk("mrst_cnt", count_out, 0);
    chk("mrst_err", err, 0);
    chk("mrst_busy", busy, 0);
    din = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_valid(3000, n, got);
    chk("mrst_novalid", got, 0);

    sym(751);
    frame_end("fresh", 4'b0001, 1, 1'b0, LAT_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
